// File: rtl/divider_taint_track_word_pkg.sv
// Purpose : shared FSM state encoding and taint width for the taint-tracking divider.
// Latency : n/a (declarations only).
// Backpr. : n/a (declarations only).
package divider_taint_track_word_pkg;

    // Every taint tag is a single bit.
    localparam int TAINT_W = 1;

    // FSM state encoding.
    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/divider_datapath_taint_track_word.sv
// Purpose : operand, remainder-accumulator, quotient and datapath-taint registers of the
//           restoring divider. It performs one MSB-first shift-subtract step per asserted step.
// Latency : one quotient bit per step; the results load on the step that has finish set.
// Backpr. : none. The controlling FSM sequences load/step/finish.
// Ports   : clk, rst (sync, active-low); load/step/finish from the FSM; dividend/divisor
//           operands; taint_in as the combined taint to latch on load; quotient/remainder
//           result registers; data_t as the datapath taint. Define DIV_TAINT_ZERO_FLAG_EN
//           to add divisor_t plus the div_zero/div_zero_t flag registers.
module divider_datapath_taint_track_word
    import divider_taint_track_word_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic               finish,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    input  logic [TAINT_W-1:0] taint_in,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic [TAINT_W-1:0] data_t
`ifdef DIV_TAINT_ZERO_FLAG_EN
    ,
    input  logic [TAINT_W-1:0] divisor_t,
    output logic               div_zero,
    output logic [TAINT_W-1:0] div_zero_t
`endif
);

    // dq_q begins holding the dividend. Each step shifts the dividend's MSB out
    // and moves the new quotient bit in at the LSB. After WIDTH steps, dq_q
    // holds the quotient.
    logic [WIDTH-1:0]   dq_q,     dq_d;
    logic [WIDTH-1:0]   dvs_q,    dvs_d;
    logic [WIDTH-1:0]   acc_q,    acc_d;
    logic [WIDTH-1:0]   quot_q,   quot_d;
    logic [WIDTH-1:0]   rem_q,    rem_d;
    logic [TAINT_W-1:0] data_t_q, data_t_d;

    logic [WIDTH:0]     shifted;
    logic               fits;
    logic [WIDTH-1:0]   diff;
    logic [WIDTH-1:0]   acc_next;
    logic [WIDTH-1:0]   dq_next;

    always_comb begin
        // Trial subtraction on the (WIDTH+1)-bit partial remainder.
        shifted = {acc_q, dq_q[WIDTH-1]};
        fits    = (shifted >= {1'b0, dvs_q});
        // When the trial fits, the difference is below the divisor, so it
        // fits in WIDTH bits. A WIDTH-bit subtraction therefore yields the
        // exact new remainder.
        diff     = shifted[WIDTH-1:0] - dvs_q;
        acc_next = fits ? diff : shifted[WIDTH-1:0];
        dq_next  = {dq_q[WIDTH-2:0], fits};

        dq_d     = dq_q;
        dvs_d    = dvs_q;
        acc_d    = acc_q;
        quot_d   = quot_q;
        rem_d    = rem_q;
        data_t_d = data_t_q;

        if (load) begin
            dq_d     = dividend;
            dvs_d    = divisor;
            acc_d    = '0;
            data_t_d = taint_in;
        end else if (step) begin
            dq_d  = dq_next;
            acc_d = acc_next;
            // The results stay frozen until the final step. This holds the
            // previous result stable for the whole run.
            if (finish) begin
                quot_d = dq_next;
                rem_d  = acc_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            dq_q     <= '0;
            dvs_q    <= '0;
            acc_q    <= '0;
            quot_q   <= '0;
            rem_q    <= '0;
            data_t_q <= '0;
        end else begin
            dq_q     <= dq_d;
            dvs_q    <= dvs_d;
            acc_q    <= acc_d;
            quot_q   <= quot_d;
            rem_q    <= rem_d;
            data_t_q <= data_t_d;
        end
    end

    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign data_t    = data_t_q;

`ifdef DIV_TAINT_ZERO_FLAG_EN
    logic               div_zero_q,   div_zero_d;
    logic [TAINT_W-1:0] div_zero_t_q, div_zero_t_d;

    always_comb begin
        div_zero_d   = div_zero_q;
        div_zero_t_d = div_zero_t_q;
        if (load) begin
            div_zero_d   = (divisor == '0);
            div_zero_t_d = divisor_t;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_zero_q   <= 1'b0;
            div_zero_t_q <= '0;
        end else begin
            div_zero_q   <= div_zero_d;
            div_zero_t_q <= div_zero_t_d;
        end
    end

    assign div_zero   = div_zero_q;
    assign div_zero_t = div_zero_t_q;
`else
    // Divide-by-zero flag is not built; no extra state.
`endif

endmodule

// File: rtl/divider_taint_track_word.sv
// Purpose : constant-time restoring divider with word-level taint tracking on data and control.
// Latency : start is sampled at an IDLE edge; quotientDone follows WIDTH+1 edges after the
//           cycle start was presented. Latency does not depend on operand values.
// Backpr. : none. start is ignored outside IDLE, and a run can be neither restarted nor aborted.
// Ports   : clk; rst (sync, active-low); start/start_t; dividend/dividend_t;
//           divisor/divisor_t; quotient/quotient_t; remainder/remainder_t;
//           quotientDone/quotientDone_t. Define DIV_TAINT_ZERO_FLAG_EN to add
//           divByZero/divByZero_t.
module divider_taint_track_word
    import divider_taint_track_word_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [TAINT_W-1:0] start_t,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [TAINT_W-1:0] dividend_t,
    input  logic [WIDTH-1:0]   divisor,
    input  logic [TAINT_W-1:0] divisor_t,
    output logic [WIDTH-1:0]   quotient,
    output logic [TAINT_W-1:0] quotient_t,
    output logic [WIDTH-1:0]   remainder,
    output logic [TAINT_W-1:0] remainder_t,
    output logic               quotientDone,
    output logic [TAINT_W-1:0] quotientDone_t
`ifdef DIV_TAINT_ZERO_FLAG_EN
    ,
    output logic               divByZero,
    output logic [TAINT_W-1:0] divByZero_t
`endif
);

    localparam int           CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state_q,  state_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [TAINT_W-1:0] ctrl_t_q, ctrl_t_d;

    logic               load;
    logic               step;
    logic               finish;
    logic [TAINT_W-1:0] taint_in;
    logic [TAINT_W-1:0] data_t;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ctrl_t_d = ctrl_t_q;
        load     = 1'b0;
        step     = 1'b0;
        finish   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Control taint tracks start_t while idle. It freezes once a
                // run begins, so it describes the start that launched the run.
                ctrl_t_d = start_t;
                if (start) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                step = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    finish  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            ctrl_t_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ctrl_t_q <= ctrl_t_d;
        end
    end

    // A tainted start strobe taints the results it produces. Whether the
    // operands were loaded at all depends on that strobe (implicit flow).
    assign taint_in = dividend_t | divisor_t | start_t;

    divider_datapath_taint_track_word #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .step       (step),
        .finish     (finish),
        .dividend   (dividend),
        .divisor    (divisor),
        .taint_in   (taint_in),
        .quotient   (quotient),
        .remainder  (remainder),
        .data_t     (data_t)
`ifdef DIV_TAINT_ZERO_FLAG_EN
        ,
        .divisor_t  (divisor_t),
        .div_zero   (divByZero),
        .div_zero_t (divByZero_t)
`endif
    );

    assign quotient_t     = data_t;
    assign remainder_t    = data_t;
    assign quotientDone   = (state_q == ST_DONE);
    assign quotientDone_t = ctrl_t_q;

endmodule

// File: tb/tb_divider_taint_track_word.sv
module tb_divider_taint_track_word;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic         start_t;
    logic [W-1:0] dividend;
    logic         dividend_t;
    logic [W-1:0] divisor;
    logic         divisor_t;
    logic [W-1:0] quotient;
    logic         quotient_t;
    logic [W-1:0] remainder;
    logic         remainder_t;
    logic         quotientDone;
    logic         quotientDone_t;
`ifdef DIV_TAINT_ZERO_FLAG_EN
    logic         divByZero;
    logic         divByZero_t;
`endif

    divider_taint_track_word #(.WIDTH(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .start_t        (start_t),
        .dividend       (dividend),
        .dividend_t     (dividend_t),
        .divisor        (divisor),
        .divisor_t      (divisor_t),
        .quotient       (quotient),
        .quotient_t     (quotient_t),
        .remainder      (remainder),
        .remainder_t    (remainder_t),
        .quotientDone   (quotientDone),
        .quotientDone_t (quotientDone_t)
`ifdef DIV_TAINT_ZERO_FLAG_EN
        ,
        .divByZero      (divByZero),
        .divByZero_t    (divByZero_t)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [W-1:0] dvd;
        logic [W-1:0] dvs;
        logic         dvd_t;
        logic         dvs_t;
        logic         st_t;
        logic [W-1:0] exp_q;
        logic [W-1:0] exp_r;
        logic         exp_dt;
        logic         exp_ct;
    } vec_t;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         qt;
        logic         rt;
        logic         ct;
        logic         dz;
        logic         dzt;
        int           lat;
        logic         extra_done;
        logic [W-1:0] q_hold;
        logic [W-1:0] r_hold;
    } res_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Present start for one cycle, then measure the cycles until done. The
    // operand inputs are scrambled during the run so the check proves they
    // were latched.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic at, input logic bt, input logic stt,
                         output res_t res);
        dividend = a; divisor = b; dividend_t = at; divisor_t = bt; start_t = stt;
        start = 1'b1;
        tick();
        start = 1'b0;
        dividend = W'($urandom); divisor = W'($urandom);
        dividend_t = 1'b0; divisor_t = 1'b0; start_t = 1'b0;
        res.lat = 1;
        while (quotientDone !== 1'b1 && res.lat < 20) begin
            tick();
            res.lat++;
        end
        res.q  = quotient;
        res.r  = remainder;
        res.qt = quotient_t;
        res.rt = remainder_t;
        res.ct = quotientDone_t;
`ifdef DIV_TAINT_ZERO_FLAG_EN
        res.dz  = divByZero;
        res.dzt = divByZero_t;
`else
        res.dz  = 1'b0;
        res.dzt = 1'b0;
`endif
        res.extra_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (quotientDone !== 1'b0) res.extra_done = 1'b1;
        end
        res.q_hold = quotient;
        res.r_hold = remainder;
    endtask

    task automatic check_res(input string tag, input res_t res,
                             input logic [W-1:0] eq, input logic [W-1:0] er,
                             input logic edt, input logic ect,
                             input logic edz, input logic edzt);
        check({tag, " latency"},    64'(res.lat), 64'(W + 1));
        check({tag, " quotient"},   64'(res.q), 64'(eq));
        check({tag, " remainder"},  64'(res.r), 64'(er));
        check({tag, " quotient_t"}, 64'(res.qt), 64'(edt));
        check({tag, " remainder_t"}, 64'(res.rt), 64'(edt));
        check({tag, " done_t"},     64'(res.ct), 64'(ect));
        check({tag, " single done"}, 64'(res.extra_done), 64'(0));
        check({tag, " q hold"},     64'(res.q_hold), 64'(eq));
        check({tag, " r hold"},     64'(res.r_hold), 64'(er));
`ifdef DIV_TAINT_ZERO_FLAG_EN
        check({tag, " divByZero"},   64'(res.dz), 64'(edz));
        check({tag, " divByZero_t"}, 64'(res.dzt), 64'(edzt));
`else
        if (edz === 1'bx || edzt === 1'bx) $display("note: unknown zero-flag expectation in %s", tag);
`endif
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, " quotient"},    64'(quotient), 64'(0));
        check({tag, " remainder"},   64'(remainder), 64'(0));
        check({tag, " quotientDone"}, 64'(quotientDone), 64'(0));
        check({tag, " quotient_t"},  64'(quotient_t), 64'(0));
        check({tag, " remainder_t"}, 64'(remainder_t), 64'(0));
        check({tag, " done_t"},      64'(quotientDone_t), 64'(0));
`ifdef DIV_TAINT_ZERO_FLAG_EN
        check({tag, " divByZero"},   64'(divByZero), 64'(0));
        check({tag, " divByZero_t"}, 64'(divByZero_t), 64'(0));
`endif
    endtask

    initial begin
        res_t res;
        int   lat;
        int   dones;

        //        dvd  dvs dvd_t dvs_t st_t  q    r  dt ct
        vecs[0] = '{100,   7, 0, 0, 0,  14,   2, 0, 0};
        vecs[1] = '{255,   1, 0, 0, 0, 255,   0, 0, 0};
        vecs[2] = '{  0, 200, 0, 0, 0,   0,   0, 0, 0};
        vecs[3] = '{ 37,   0, 0, 0, 0, 255,  37, 0, 0};
        vecs[4] = '{100,   7, 1, 0, 0,  14,   2, 1, 0};
        vecs[5] = '{  9,   3, 0, 0, 1,   3,   0, 1, 1};
        vecs[6] = '{200,  13, 0, 1, 0,  15,   5, 1, 0};
        vecs[7] = '{  5,   9, 0, 0, 0,   0,   5, 0, 0};

        rst = 1'b0; start = 1'b0; start_t = 1'b0;
        dividend = '0; divisor = '0; dividend_t = 1'b0; divisor_t = 1'b0;
        tick();
        tick();
        check_zero_outputs("reset");
        rst = 1'b1;
        tick();

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].dvd, vecs[i].dvs, vecs[i].dvd_t, vecs[i].dvs_t, vecs[i].st_t, res);
            check_res($sformatf("vec%0d", i), res, vecs[i].exp_q, vecs[i].exp_r,
                      vecs[i].exp_dt, vecs[i].exp_ct,
                      (vecs[i].dvs == 0), vecs[i].dvs_t);
        end

        // Second start during RUN must be ignored.
        dividend = 8'd100; divisor = 8'd7; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1;
        tick(); lat++;
        tick(); lat++;
        dividend = 8'd50; divisor = 8'd3; start = 1'b1; start_t = 1'b1; dividend_t = 1'b1;
        tick(); lat++;
        start = 1'b0; start_t = 1'b0; dividend_t = 1'b0;
        while (quotientDone !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        check("restart latency", 64'(lat), 64'(W + 1));
        check("restart quotient", 64'(quotient), 64'(14));
        check("restart remainder", 64'(remainder), 64'(2));
        check("restart quotient_t", 64'(quotient_t), 64'(0));
        check("restart done_t", 64'(quotientDone_t), 64'(0));
        dones = 0;
        for (int k = 0; k < 14; k++) begin
            tick();
            if (quotientDone === 1'b1) dones++;
        end
        check("restart no second done", 64'(dones), 64'(0));
        check("restart result kept", 64'(quotient), 64'(14));

        // Reset in the middle of a run.
        dividend = 8'd200; divisor = 8'd3; dividend_t = 1'b1; start_t = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; dividend_t = 1'b0; start_t = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b0;
        tick();
        check_zero_outputs("midrun reset");
        rst = 1'b1;
        dones = 0;
        for (int k = 0; k < 14; k++) begin
            tick();
            if (quotientDone === 1'b1) dones++;
        end
        check("midrun reset no done", 64'(dones), 64'(0));
        do_op(8'd200, 8'd3, 1'b0, 1'b0, 1'b0, res);
        check_res("after reset", res, 8'd66, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0);

        // Random operands against an arithmetic reference.
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] a, b, eq, er;
            logic at, bt, st;
            a  = W'($urandom_range(0, 255));
            b  = (i % 7 == 0) ? '0 : W'($urandom_range(0, 255));
            at = 1'($urandom_range(0, 1));
            bt = 1'($urandom_range(0, 1));
            st = 1'($urandom_range(0, 1));
            eq = (b == 0) ? {W{1'b1}} : a / b;
            er = (b == 0) ? a : a % b;
            do_op(a, b, at, bt, st, res);
            check_res($sformatf("rand%0d", i), res, eq, er, at | bt | st, st, (b == 0), bt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
